// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the I-cache, D-cache, arbiter and main memory.
// Caches and memory form the master side; the arbiter plugs in as slave.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        output i_mem_rdata, i_mem_ready,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        input  i_mem_rdata, i_mem_ready,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way arbiter for the single main-memory block port (I-cache vs D-cache).
// A grant is held until mem_ready or until the owner drops its request.
module mem_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             proc_reset,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt,
    output logic             proto_err
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT_I, S_GRANT_D} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_i_cnt;
    logic [CNT_W-1:0]  r_d_cnt;
    logic              r_proto_err;

    logic              w_req_i;
    logic              w_req_d;
    logic              w_pick_d;
    logic              w_both;
    logic              w_rd;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rdy_i;
    logic              w_rdy_d;
    logic              w_inc_i;
    logic              w_inc_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_req_i  = bus.i_mem_read | bus.i_mem_write;
        w_req_d  = bus.d_mem_read | bus.d_mem_write;
        w_both   = (bus.i_mem_read & bus.i_mem_write) | (bus.d_mem_read & bus.d_mem_write);
        // On contention D wins if fixed priority, else whoever was not granted last
        w_pick_d = (FIXED_PRIO != 0) || !r_last_d;
        w_next   = r_state;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        w_rdy_i  = 1'b0;
        w_rdy_d  = 1'b0;
        w_inc_i  = 1'b0;
        w_inc_d  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_i && w_req_d) w_next = w_pick_d ? S_GRANT_D : S_GRANT_I;
                else if (w_req_i)       w_next = S_GRANT_I;
                else if (w_req_d)       w_next = S_GRANT_D;
            end
            S_GRANT_I: begin
                w_rd    = bus.i_mem_read;
                w_wr    = bus.i_mem_write;
                w_addr  = bus.i_mem_addr;
                w_wdata = bus.i_mem_wdata;
                w_rdy_i = bus.mem_ready;
                if (!w_req_i) begin
                    w_next = S_IDLE;
                end else if (bus.mem_ready) begin
                    w_inc_i = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_GRANT_D: begin
                w_rd    = bus.d_mem_read;
                w_wr    = bus.d_mem_write;
                w_addr  = bus.d_mem_addr;
                w_wdata = bus.d_mem_wdata;
                w_rdy_d = bus.mem_ready;
                if (!w_req_d) begin
                    w_next = S_IDLE;
                end else if (bus.mem_ready) begin
                    w_inc_d = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_last_d    <= 1'b0;
            r_i_cnt     <= '0;
            r_d_cnt     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_next != S_IDLE) r_last_d <= (w_next == S_GRANT_D);
            if (w_inc_i) r_i_cnt <= sat_inc(r_i_cnt);
            if (w_inc_d) r_d_cnt <= sat_inc(r_d_cnt);
            if (w_both)  r_proto_err <= 1'b1;
        end
    end

    assign bus.mem_read    = w_rd;
    assign bus.mem_write   = w_wr;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_wdata   = w_wdata;
    assign bus.i_mem_ready = w_rdy_i;
    assign bus.d_mem_ready = w_rdy_d;
    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;
    assign i_grant_cnt     = r_i_cnt;
    assign d_grant_cnt     = r_d_cnt;
    assign proto_err       = r_proto_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin/16-bit counters,
// instance 1 is fixed-priority/2-bit counters. Inputs change on the falling edge.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    logic         i_rd[2], i_wr[2], d_rd[2], d_wr[2], m_ready[2];
    logic [27:0]  i_addr[2], d_addr[2];
    logic [127:0] i_wdata[2], d_wdata[2], m_rdata[2];
    logic         o_mrd[2], o_mwr[2], o_irdy[2], o_drdy[2], o_perr[2];
    logic [27:0]  o_maddr[2];
    logic [127:0] o_mwd[2], o_irdata[2], o_drdata[2];
    logic [15:0]  o_icnt[2], o_dcnt[2];

    logic [15:0]  cnt0_i, cnt0_d;
    logic [1:0]   cnt1_i, cnt1_d;
    logic         perr0, perr1;

    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) if0 ();
    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) if1 ();

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(16), .FIXED_PRIO(0)) dut0 (
        .clk(clk), .proc_reset(rst), .bus(if0.slave),
        .i_grant_cnt(cnt0_i), .d_grant_cnt(cnt0_d), .proto_err(perr0));
    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(2), .FIXED_PRIO(1)) dut1 (
        .clk(clk), .proc_reset(rst), .bus(if1.slave),
        .i_grant_cnt(cnt1_i), .d_grant_cnt(cnt1_d), .proto_err(perr1));

    assign if0.i_mem_read = i_rd[0];     assign if1.i_mem_read = i_rd[1];
    assign if0.i_mem_write = i_wr[0];    assign if1.i_mem_write = i_wr[1];
    assign if0.i_mem_addr = i_addr[0];   assign if1.i_mem_addr = i_addr[1];
    assign if0.i_mem_wdata = i_wdata[0]; assign if1.i_mem_wdata = i_wdata[1];
    assign if0.d_mem_read = d_rd[0];     assign if1.d_mem_read = d_rd[1];
    assign if0.d_mem_write = d_wr[0];    assign if1.d_mem_write = d_wr[1];
    assign if0.d_mem_addr = d_addr[0];   assign if1.d_mem_addr = d_addr[1];
    assign if0.d_mem_wdata = d_wdata[0]; assign if1.d_mem_wdata = d_wdata[1];
    assign if0.mem_rdata = m_rdata[0];   assign if1.mem_rdata = m_rdata[1];
    assign if0.mem_ready = m_ready[0];   assign if1.mem_ready = m_ready[1];

    assign o_mrd[0] = if0.mem_read;      assign o_mrd[1] = if1.mem_read;
    assign o_mwr[0] = if0.mem_write;     assign o_mwr[1] = if1.mem_write;
    assign o_maddr[0] = if0.mem_addr;    assign o_maddr[1] = if1.mem_addr;
    assign o_mwd[0] = if0.mem_wdata;     assign o_mwd[1] = if1.mem_wdata;
    assign o_irdy[0] = if0.i_mem_ready;  assign o_irdy[1] = if1.i_mem_ready;
    assign o_drdy[0] = if0.d_mem_ready;  assign o_drdy[1] = if1.d_mem_ready;
    assign o_irdata[0] = if0.i_mem_rdata; assign o_irdata[1] = if1.i_mem_rdata;
    assign o_drdata[0] = if0.d_mem_rdata; assign o_drdata[1] = if1.d_mem_rdata;
    assign o_icnt[0] = cnt0_i;           assign o_icnt[1] = {14'd0, cnt1_i};
    assign o_dcnt[0] = cnt0_d;           assign o_dcnt[1] = {14'd0, cnt1_d};
    assign o_perr[0] = perr0;            assign o_perr[1] = perr1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            i_rd[k] = 1'b0; i_wr[k] = 1'b0; i_addr[k] = '0; i_wdata[k] = '0;
            d_rd[k] = 1'b0; d_wr[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
            m_rdata[k] = '0; m_ready[k] = 1'b0;
        end
    endtask

    // Leaves the caller on a falling edge with both arbiters idle.
    task automatic do_reset();
        clear_inputs();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if ({o_mrd[k], o_mwr[k]} !== 2'b00) begin n_fail++; $display("FAIL reset_req[%0d]: got %b, expected 00", k, {o_mrd[k], o_mwr[k]}); end
                n_cmp++; if ({o_icnt[k], o_dcnt[k]} !== 32'd0) begin n_fail++; $display("FAIL reset_cnt[%0d]: got %h, expected 0", k, {o_icnt[k], o_dcnt[k]}); end
                n_cmp++; if (o_perr[k] !== 1'b0) begin n_fail++; $display("FAIL reset_perr[%0d]: got %b, expected 0", k, o_perr[k]); end
            end
        end
    endtask

    task automatic test_i_read();
        logic [127:0] pat;
        pat = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        do_reset();
        i_rd[0] = 1'b1; i_addr[0] = 28'h0000010; #1;
        n_cmp++; if (o_mrd[0] !== 1'b0) begin n_fail++; $display("FAIL iread_latency: got %b, expected 0", o_mrd[0]); end
        @(negedge clk); #1;
        n_cmp++; if ({o_mrd[0], o_mwr[0]} !== 2'b10) begin n_fail++; $display("FAIL iread_req: got %b, expected 10", {o_mrd[0], o_mwr[0]}); end
        n_cmp++; if (o_maddr[0] !== 28'h0000010) begin n_fail++; $display("FAIL iread_addr: got %h, expected 0000010", o_maddr[0]); end
        repeat (3) begin
            @(negedge clk); #1;
            n_cmp++; if ({o_mrd[0], o_irdy[0]} !== 2'b10) begin n_fail++; $display("FAIL iread_hold: got %b, expected 10", {o_mrd[0], o_irdy[0]}); end
        end
        @(negedge clk); m_ready[0] = 1'b1; m_rdata[0] = pat; #1;
        n_cmp++; if ({o_irdy[0], o_drdy[0]} !== 2'b10) begin n_fail++; $display("FAIL iread_ready: got %b, expected 10", {o_irdy[0], o_drdy[0]}); end
        n_cmp++; if (o_irdata[0] !== pat) begin n_fail++; $display("FAIL iread_rdata: got %h, expected %h", o_irdata[0], pat); end
        @(negedge clk); m_ready[0] = 1'b0; i_rd[0] = 1'b0; #1;
        n_cmp++; if (o_icnt[0] !== 16'd1) begin n_fail++; $display("FAIL iread_cnt: got %0d, expected 1", o_icnt[0]); end
        n_cmp++; if (o_mrd[0] !== 1'b0) begin n_fail++; $display("FAIL iread_release: got %b, expected 0", o_mrd[0]); end
    endtask

    task automatic test_contention();
        do_reset();
        i_rd[0] = 1'b1; i_addr[0] = 28'h1234567;
        d_wr[0] = 1'b1; d_addr[0] = 28'h7654321; d_wdata[0] = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
        @(negedge clk); #1;
        n_cmp++; if ({o_mrd[0], o_mwr[0]} !== 2'b01) begin n_fail++; $display("FAIL cont_d_first: got %b, expected 01", {o_mrd[0], o_mwr[0]}); end
        n_cmp++; if (o_mwd[0] !== d_wdata[0]) begin n_fail++; $display("FAIL cont_wdata: got %h, expected %h", o_mwd[0], d_wdata[0]); end
        n_cmp++; if (o_maddr[0] !== 28'h7654321) begin n_fail++; $display("FAIL cont_daddr: got %h, expected 7654321", o_maddr[0]); end
        m_ready[0] = 1'b1; #1;
        n_cmp++; if ({o_drdy[0], o_irdy[0]} !== 2'b10) begin n_fail++; $display("FAIL cont_dready: got %b, expected 10", {o_drdy[0], o_irdy[0]}); end
        @(negedge clk); m_ready[0] = 1'b0; d_wr[0] = 1'b0; #1;
        n_cmp++; if ({o_mrd[0], o_mwr[0]} !== 2'b00) begin n_fail++; $display("FAIL cont_gap: got %b, expected 00", {o_mrd[0], o_mwr[0]}); end
        @(negedge clk); #1;
        n_cmp++; if ({o_mrd[0], o_maddr[0]} !== {1'b1, 28'h1234567}) begin n_fail++; $display("FAIL cont_i_next: got %h, expected 11234567", {o_mrd[0], o_maddr[0]}); end
        m_ready[0] = 1'b1; #1;
        @(negedge clk); m_ready[0] = 1'b0; i_rd[0] = 1'b0; #1;
        n_cmp++; if ({o_icnt[0], o_dcnt[0]} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL cont_cnts: got %h, expected 00010001", {o_icnt[0], o_dcnt[0]}); end
    endtask

    // Codes: 1 = D write, 2 = I read, 3 = D read.
    task automatic test_wb_refill(input int k, input int e0, input int e1, input int e2);
        int  got[3];
        int  ex[3];
        int  n;
        bit  idone, ddone;
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        got[0] = 0; got[1] = 0; got[2] = 0;
        n = 0; idone = 1'b0; ddone = 1'b0;
        do_reset();
        d_wr[k] = 1'b1; d_addr[k] = 28'h0000200; d_wdata[k] = 128'h77;
        i_rd[k] = 1'b1; i_addr[k] = 28'h0000300;
        for (int c = 0; c < 30 && n < 3; c++) begin
            #1; m_ready[k] = o_mrd[k] | o_mwr[k]; #1;
            if (o_irdy[k]) begin got[n] = 2; n++; idone = 1'b1; end
            else if (o_drdy[k]) begin got[n] = o_mwr[k] ? 1 : 3; n++; ddone = 1'b1; end
            @(negedge clk); m_ready[k] = 1'b0;
            if (idone) begin i_rd[k] = 1'b0; idone = 1'b0; end
            if (ddone) begin
                ddone = 1'b0;
                if (d_wr[k]) begin d_wr[k] = 1'b0; d_rd[k] = 1'b1; end
                else d_rd[k] = 1'b0;
            end
        end
        n_cmp++; if (n !== 3) begin n_fail++; $display("FAIL wbref_count[%0d]: got %0d completions, expected 3", k, n); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (got[j] !== ex[j]) begin n_fail++; $display("FAIL wbref_order[%0d][%0d]: got %0d, expected %0d", k, j, got[j], ex[j]); end
        end
        #1;
        n_cmp++; if ({o_icnt[k], o_dcnt[k]} !== {16'd1, 16'd2}) begin n_fail++; $display("FAIL wbref_cnts[%0d]: got %h, expected 00010002", k, {o_icnt[k], o_dcnt[k]}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_rd[0] = 1'b1; d_addr[0] = 28'h0ABCDEF;
        @(negedge clk); #1;
        n_cmp++; if (o_mrd[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_granted: got %b, expected 1", o_mrd[0]); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; d_rd[0] = 1'b0; m_ready[0] = 1'b1; #1;
        n_cmp++; if ({o_mrd[0], o_drdy[0]} !== 2'b00) begin n_fail++; $display("FAIL rmid_after: got %b, expected 00", {o_mrd[0], o_drdy[0]}); end
        @(negedge clk); m_ready[0] = 1'b0; #1;
        n_cmp++; if (o_dcnt[0] !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d, expected 0", o_dcnt[0]); end
        n_cmp++; if (o_mrd[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b, expected 0", o_mrd[0]); end
    endtask

    task automatic test_proto_err();
        do_reset(); #1;
        n_cmp++; if (o_perr[0] !== 1'b0) begin n_fail++; $display("FAIL perr_init: got %b, expected 0", o_perr[0]); end
        d_rd[0] = 1'b1; d_wr[0] = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (o_perr[0] !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b, expected 1", o_perr[0]); end
        n_cmp++; if ({o_mrd[0], o_mwr[0]} !== 2'b11) begin n_fail++; $display("FAIL perr_forward: got %b, expected 11", {o_mrd[0], o_mwr[0]}); end
        d_rd[0] = 1'b0; d_wr[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (o_perr[0] !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b, expected 1", o_perr[0]); end
        n_cmp++; if (o_dcnt[0] !== 16'd0) begin n_fail++; $display("FAIL perr_abort_cnt: got %0d, expected 0", o_dcnt[0]); end
        do_reset(); #1;
        n_cmp++; if (o_perr[0] !== 1'b0) begin n_fail++; $display("FAIL perr_clear: got %b, expected 0", o_perr[0]); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int t = 0; t < 5; t++) begin
            i_rd[1] = 1'b1; i_addr[1] = 28'(t);
            @(negedge clk); #1;
            n_cmp++; if (o_mrd[1] !== 1'b1) begin n_fail++; $display("FAIL sat_grant[%0d]: got %b, expected 1", t, o_mrd[1]); end
            m_ready[1] = 1'b1; #1;
            n_cmp++; if (o_irdy[1] !== 1'b1) begin n_fail++; $display("FAIL sat_ready[%0d]: got %b, expected 1", t, o_irdy[1]); end
            @(negedge clk); i_rd[1] = 1'b0; m_ready[1] = 1'b0; #1;
            n_cmp++; if (o_icnt[1] !== 16'((t + 1 > 3) ? 3 : t + 1)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d, expected %0d", t, o_icnt[1], (t + 1 > 3) ? 3 : t + 1); end
        end
    endtask

    // Reference model: owner of the bus (0 none, 1 I, 2 D), who was granted
    // last, and completed-transaction tallies; memory answers after 0-3 cycles.
    task automatic test_random(input int k, input int ncyc);
        int   own, last, delay, ci, cd, cmax, win;
        bit   idone, ddone;
        logic ereq_i, ereq_d, e_rd, e_wr, e_irdy, e_drdy;
        logic [27:0]  e_addr;
        logic [127:0] e_wd;
        cmax = (k == 0) ? 65535 : 3;
        do_reset();
        own = 0; last = 1; delay = 0; ci = 0; cd = 0; idone = 1'b0; ddone = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (idone) begin i_rd[k] = 1'b0; i_wr[k] = 1'b0; idone = 1'b0; end
            else if ((i_rd[k] | i_wr[k]) && $urandom_range(0, 24) == 0) begin i_rd[k] = 1'b0; i_wr[k] = 1'b0; end
            else if (!(i_rd[k] | i_wr[k]) && $urandom_range(0, 2) == 0) begin
                i_rd[k] = 1'($urandom_range(0, 1)); i_wr[k] = ~i_rd[k];
                i_addr[k] = 28'($urandom()); i_wdata[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (ddone) begin
                ddone = 1'b0;
                if ($urandom_range(0, 1) == 0) begin d_rd[k] = 1'b1; d_wr[k] = 1'b0; d_addr[k] = 28'($urandom()); end
                else begin d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
            end else if ((d_rd[k] | d_wr[k]) && $urandom_range(0, 24) == 0) begin d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
            else if (!(d_rd[k] | d_wr[k]) && $urandom_range(0, 2) == 0) begin
                d_rd[k] = 1'($urandom_range(0, 1)); d_wr[k] = ~d_rd[k];
                d_addr[k] = 28'($urandom()); d_wdata[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            ereq_i = i_rd[k] | i_wr[k];
            ereq_d = d_rd[k] | d_wr[k];
            m_rdata[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ((own == 1 && ereq_i) || (own == 2 && ereq_d)) begin
                m_ready[k] = (delay == 0);
                if (delay > 0) delay--;
            end else begin
                m_ready[k] = (own == 0) && ($urandom_range(0, 7) == 0);
            end
            e_rd   = (own == 1) ? i_rd[k]    : (own == 2) ? d_rd[k]    : 1'b0;
            e_wr   = (own == 1) ? i_wr[k]    : (own == 2) ? d_wr[k]    : 1'b0;
            e_addr = (own == 1) ? i_addr[k]  : (own == 2) ? d_addr[k]  : 28'd0;
            e_wd   = (own == 1) ? i_wdata[k] : (own == 2) ? d_wdata[k] : 128'd0;
            e_irdy = (own == 1) && m_ready[k];
            e_drdy = (own == 2) && m_ready[k];
            #1;
            n_cmp++; if ({o_mrd[k], o_mwr[k]} !== {e_rd, e_wr}) begin n_fail++; $display("FAIL rand_req[%0d] cyc %0d: got %b, expected %b", k, c, {o_mrd[k], o_mwr[k]}, {e_rd, e_wr}); end
            n_cmp++; if (o_maddr[k] !== e_addr) begin n_fail++; $display("FAIL rand_addr[%0d] cyc %0d: got %h, expected %h", k, c, o_maddr[k], e_addr); end
            n_cmp++; if (o_mwd[k] !== e_wd) begin n_fail++; $display("FAIL rand_wdata[%0d] cyc %0d: got %h, expected %h", k, c, o_mwd[k], e_wd); end
            n_cmp++; if ({o_irdy[k], o_drdy[k]} !== {e_irdy, e_drdy}) begin n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %b, expected %b", k, c, {o_irdy[k], o_drdy[k]}, {e_irdy, e_drdy}); end
            n_cmp++; if ({o_irdata[k], o_drdata[k]} !== {m_rdata[k], m_rdata[k]}) begin n_fail++; $display("FAIL rand_rdata[%0d] cyc %0d: got %h/%h, expected %h", k, c, o_irdata[k], o_drdata[k], m_rdata[k]); end
            n_cmp++; if (o_icnt[k] !== 16'(ci)) begin n_fail++; $display("FAIL rand_icnt[%0d] cyc %0d: got %0d, expected %0d", k, c, o_icnt[k], ci); end
            n_cmp++; if (o_dcnt[k] !== 16'(cd)) begin n_fail++; $display("FAIL rand_dcnt[%0d] cyc %0d: got %0d, expected %0d", k, c, o_dcnt[k], cd); end
            n_cmp++; if (o_perr[k] !== 1'b0) begin n_fail++; $display("FAIL rand_perr[%0d] cyc %0d: got %b, expected 0", k, c, o_perr[k]); end
            if (own == 0) begin
                win = 0;
                if (ereq_i && ereq_d) win = (k == 1 || last == 1) ? 2 : 1;
                else if (ereq_i)      win = 1;
                else if (ereq_d)      win = 2;
                if (win != 0) begin own = win; last = win; delay = $urandom_range(0, 3); end
            end else if (own == 1) begin
                if (!ereq_i) own = 0;
                else if (m_ready[k]) begin ci = (ci < cmax) ? ci + 1 : ci; idone = 1'b1; own = 0; end
            end else begin
                if (!ereq_d) own = 0;
                else if (m_ready[k]) begin cd = (cd < cmax) ? cd + 1 : cd; ddone = 1'b1; own = 0; end
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_i_read();
        test_contention();
        test_wb_refill(0, 1, 2, 3);
        test_wb_refill(1, 1, 3, 2);
        test_reset_mid();
        test_proto_err();
        test_saturation();
        test_random(0, 800);
        test_random(1, 800);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
